pipe_datapath_execute_md: RTL and testbench
===========================================

// Module: pipe_datapath_execute_md
// PURPOSE
// - Generalised RV32IM execute stage: forwarding muxes, ALU, PC+imm adder, full branch compare, multi-cycle MUL/DIV unit.
// - Sits between ID/EX and EX/MEM pipeline registers.
// - Stalls the pipeline via o_stallE while a MUL/DIV op is in flight.
// - Branch compare is exact for BLT/BGE/BLTU/BGEU; it does not depend on the ALU zero flag.
// PARAMETERS
// - XLEN     32  datapath width
// - N_FWD     3  forwarding sources per operand: index 0 = register file, 1..N_FWD-1 = i_fwd_data slices
// - MUL_LAT   2  multiplier pipeline depth in cycles, >=1
// - DIV_STEP  1  quotient bits resolved per cycle; XLEN % DIV_STEP == 0
// PORTS
// - i_clk              in   1                clock, rising edge
// - i_rst              in   1                asynchronous, active-high reset
// - i_dp_RD1E          in   XLEN             rs1 operand from ID/EX
// - i_dp_RD2E          in   XLEN             rs2 operand from ID/EX
// - i_dp_PCE           in   XLEN             PC of the E instruction
// - i_dp_ImmExtE       in   XLEN             extended immediate
// - i_fwd_data         in   (N_FWD-1)*XLEN   forward sources; slice k-1 is selected by sel=k
// - i_ForwardAE        in   clog2(N_FWD)     SrcA select; sel >= N_FWD selects RD1E
// - i_ForwardBE        in   clog2(N_FWD)     rs2 select; sel >= N_FWD selects RD2E
// - i_ALUSrcE          in   1                SrcB: 0 = forwarded rs2, 1 = imm
// - i_ALUCtrlE         in   4                ALU op, existing encoding
// - i_JumpE            in   2                01 = JAL, 10 = JALR
// - i_BranchE          in   1                branch instruction in E
// - i_funct3E          in   3                branch or M-op funct3
// - i_md_valid         in   1                E instruction is an M-extension op
// - i_flushE           in   1                kill the E instruction
// - o_dp_ALU           out  XLEN             ALU result, or M result in DONE
// - o_dp_WriteDataE    out  XLEN             forwarded rs2
// - o_dp_PC_Plus_immE  out  XLEN             PCE + ImmExtE, modulo 2^XLEN
// - o_PCSrcE           out  2                00 = PC+4, 01 = PC+imm, 10 = ALU (JALR)
// - o_stallE           out  1                freeze F/D/E, hold E/M bubble
// - o_md_done          out  1                one-cycle pulse when the M result is on o_dp_ALU
// BEHAVIOUR
// - Reset: FSM = IDLE, all internal registers 0, o_stallE = 0, o_md_done = 0. Combinational outputs follow their inputs.
// - Branch: eq = (A==B); lt = signed A<B; ltu = unsigned A<B, with A/B the forwarded operands.
//   BEQ eq, BNE !eq, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu; other funct3 values = not taken.
// - PCSrc priority: (BranchE & taken) -> 01; else JumpE==01 -> 01; else JumpE==10 -> 10; else 00.
//   When i_md_valid=1, o_PCSrcE is forced to 00.
// - FSM states: IDLE, MUL, DIV, DONE.
//   - IDLE & i_md_valid & !flush: latch A, forwarded rs2 and funct3.
//     MUL* -> MUL with cnt = MUL_LAT-1. DIV*/REM* -> DIV with cnt = XLEN/DIV_STEP-1.
//     Divisor 0, or signed overflow (A = -2^(XLEN-1), B = -1) -> straight to DONE.
//   - MUL/DIV: decrement cnt each cycle; at cnt==0 go to DONE.
//   - DONE: go to IDLE unconditionally. The same i_md_valid must not retrigger, because the pipeline advances on this edge.
// - o_stallE = (IDLE & i_md_valid | MUL | DIV) & !i_flushE. It is low in DONE.
// - o_md_done = (state==DONE). In DONE, o_dp_ALU = M result; otherwise it is the ALU output.
// - Latency: MUL ops hold E for MUL_LAT+2 cycles; DIV ops for XLEN/DIV_STEP+2; special-case DIV for 2.
// - MUL uses a (XLEN+1)x(XLEN+1) signed product with operands sign- or zero-extended per op.
//   MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
// - DIV is restoring division on magnitudes; quotient and remainder signs are fixed in DONE.
//   Remainder takes the dividend's sign.
// - Divide by zero: quotient = all ones, remainder = dividend.
// - Overflow: quotient = dividend, remainder = 0.
// - i_flushE in any state: next state IDLE, no o_md_done pulse, result discarded.
// - i_rst mid-operation: immediate return to IDLE, counters cleared.
// STRUCTURE
// - Add to riscv_configs.v: FUNCT3_MULDIV_* codes (MUL..REMU) and MD FSM state encodings.
// - Reuse riscv_alu, riscv_adder and riscv_mux (N_MUX_IN=N_FWD for forwarding, 2 for ALUSrc).
// - New sub-module riscv_divider holds the iterative core: start/done handshake, DIV_STEP bits per cycle.
// - The multiplier pipeline stays inline.
// TESTING
// - BLT, A=-1, B=1 (forward sel 0) -> o_PCSrcE=01. BLTU with the same operands -> 00. BGE, A=B=5 -> 01.
// - MUL, A=7, B=-3, MUL_LAT=2 -> o_stallE high 3 cycles, then DONE: o_dp_ALU=0xFFFFFFEB, o_md_done pulse.
// - MULHU, A=B=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU, A=-1, B=2 -> 0xFFFFFFFF.
// - DIV, A=-7, B=2 -> quotient 0xFFFFFFFD after 32 stall cycles + start cycle. REM, same operands -> 0xFFFFFFFF.
// - DIVU, B=0 -> 0xFFFFFFFF in 2 cycles. DIV, A=0x80000000, B=-1 -> 0x80000000; REM of the same -> 0.
// - i_flushE at cycle 5 of a DIV -> o_stallE drops the same cycle, FSM IDLE next, no done pulse.
//   i_rst at cycle 3 of a MUL -> o_stallE = 0, FSM IDLE.

Source files
------------

// File: rtl/pipe_datapath_execute_md_pkg.sv
// pipe_datapath_execute_md_pkg: shared encodings for the RV32IM execute stage
package pipe_datapath_execute_md_pkg;
  typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV, MD_DONE} md_state_e;
  typedef enum logic [2:0] {
    F3_MUL = 3'b000, F3_MULH, F3_MULHSU, F3_MULHU, F3_DIV, F3_DIVU, F3_REM, F3_REMU
  } muldiv_f3_e;
  typedef enum logic [2:0] {
    BR_BEQ = 3'b000, BR_BNE = 3'b001, BR_BLT = 3'b100, BR_BGE = 3'b101, BR_BLTU = 3'b110, BR_BGEU = 3'b111
  } branch_f3_e;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB
  } alu_op_e;
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_ALU    = 2'b10;
  localparam logic [1:0] JUMP_JAL  = 2'b01;
  localparam logic [1:0] JUMP_JALR = 2'b10;
endpackage

// File: rtl/pipe_datapath_execute_md_div.sv
// pipe_datapath_execute_md_div: iterative restoring divider on unsigned magnitudes
module pipe_datapath_execute_md_div #(
  parameter int XLEN = 32,
  parameter int DIV_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            en,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);
  logic [XLEN-1:0] r_q, q_q, d_q, r, q;
  logic [XLEN:0] t, sub;
  always_comb begin
    r = r_q;
    q = q_q;
    t = '0;
    sub = '0;
    for (int i = 0; i < DIV_STEP; i++) begin
      t = {r, q[XLEN-1]};
      sub = t - {1'b0, d_q};
      r = sub[XLEN] ? t[XLEN-1:0] : sub[XLEN-1:0];
      q = {q[XLEN-2:0], ~sub[XLEN]};
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
      q_q <= '0;
      d_q <= '0;
    end else if (start) begin
      r_q <= '0;
      q_q <= dividend;
      d_q <= divisor;
    end else if (en) begin
      r_q <= r;
      q_q <= q;
    end
  end
  assign quo = q_q;
  assign rem = r_q;
endmodule

// File: rtl/pipe_datapath_execute_md.sv
// pipe_datapath_execute_md: RV32IM execute stage with forwarding, ALU, branch resolve and MUL/DIV
module pipe_datapath_execute_md
  import pipe_datapath_execute_md_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int N_FWD = 3,
  parameter int MUL_LAT = 2,
  parameter int DIV_STEP = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [XLEN-1:0]           i_dp_RD1E,
  input  logic [XLEN-1:0]           i_dp_RD2E,
  input  logic [XLEN-1:0]           i_dp_PCE,
  input  logic [XLEN-1:0]           i_dp_ImmExtE,
  input  logic [(N_FWD-1)*XLEN-1:0] i_fwd_data,
  input  logic [$clog2(N_FWD)-1:0]  i_ForwardAE,
  input  logic [$clog2(N_FWD)-1:0]  i_ForwardBE,
  input  logic                      i_ALUSrcE,
  input  logic [3:0]                i_ALUCtrlE,
  input  logic [1:0]                i_JumpE,
  input  logic                      i_BranchE,
  input  logic [2:0]                i_funct3E,
  input  logic                      i_md_valid,
  input  logic                      i_flushE,
  output logic [XLEN-1:0]           o_dp_ALU,
  output logic [XLEN-1:0]           o_dp_WriteDataE,
  output logic [XLEN-1:0]           o_dp_PC_Plus_immE,
  output logic [1:0]                o_PCSrcE,
  output logic                      o_stallE,
  output logic                      o_md_done
);
  localparam int FW = $clog2(N_FWD);
  localparam int SW = $clog2(XLEN);
  localparam int PW = 2 * XLEN;
  localparam int CW = $clog2(XLEN / DIV_STEP + MUL_LAT + 1);
  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_y;
  logic taken;
  always_comb begin
    src_a = i_dp_RD1E;
    fwd_b = i_dp_RD2E;
    for (int k = 1; k < N_FWD; k++) begin
      if (i_ForwardAE == FW'(k)) src_a = i_fwd_data[(k-1)*XLEN +: XLEN];
      if (i_ForwardBE == FW'(k)) fwd_b = i_fwd_data[(k-1)*XLEN +: XLEN];
    end
  end
  assign src_b = i_ALUSrcE ? i_dp_ImmExtE : fwd_b;
  assign o_dp_WriteDataE = fwd_b;
  assign o_dp_PC_Plus_immE = i_dp_PCE + i_dp_ImmExtE;
  always_comb begin
    alu_y = '0;
    case (i_ALUCtrlE)
      ALU_ADD:   alu_y = src_a + src_b;
      ALU_SUB:   alu_y = src_a - src_b;
      ALU_AND:   alu_y = src_a & src_b;
      ALU_OR:    alu_y = src_a | src_b;
      ALU_XOR:   alu_y = src_a ^ src_b;
      ALU_SLL:   alu_y = src_a << src_b[SW-1:0];
      ALU_SRL:   alu_y = src_a >> src_b[SW-1:0];
      ALU_SRA:   alu_y = $unsigned($signed(src_a) >>> src_b[SW-1:0]);
      ALU_SLT:   alu_y = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU:  alu_y = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_PASSB: alu_y = src_b;
      default:   alu_y = '0;
    endcase
  end
  // Branches compare the forwarded rs2, never the immediate-muxed SrcB.
  logic eq, lt, ltu;
  assign eq  = src_a == fwd_b;
  assign lt  = $signed(src_a) < $signed(fwd_b);
  assign ltu = src_a < fwd_b;
  always_comb begin
    taken = 1'b0;
    case (i_funct3E)
      BR_BEQ:  taken = eq;
      BR_BNE:  taken = ~eq;
      BR_BLT:  taken = lt;
      BR_BGE:  taken = ~lt;
      BR_BLTU: taken = ltu;
      BR_BGEU: taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end
  assign o_PCSrcE = i_md_valid ? PC_PLUS4 :
                    (i_BranchE & taken) ? PC_TARGET :
                    (i_JumpE == JUMP_JAL) ? PC_TARGET :
                    (i_JumpE == JUMP_JALR) ? PC_ALU : PC_PLUS4;
  md_state_e state, nxt;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] a_q, b_q, dq, dr, quo, rem, md_res, lo, hi, mag_a, mag_b;
  logic [2:0] f3_q;
  logic dz_q, ov_q, is_div, b_zero, ovf, special, start_ok, a_neg, b_neg, sq_neg, sr_neg;
  logic [PW-1:0] mp [MUL_LAT];
  logic signed [PW+1:0] ma, mb;
  assign is_div   = i_funct3E[2];
  assign b_zero   = fwd_b == '0;
  assign ovf      = ~i_funct3E[0] & (src_a == {1'b1, {(XLEN-1){1'b0}}}) & (&fwd_b);
  assign special  = b_zero | ovf;
  assign start_ok = (state == MD_IDLE) & i_md_valid & ~i_flushE;
  assign nxt = i_flushE ? MD_IDLE :
               (state == MD_IDLE) ? (i_md_valid ? (~is_div ? MD_MUL : special ? MD_DONE : MD_DIV) : MD_IDLE) :
               (state == MD_DONE) ? MD_IDLE :
               (cnt == '0) ? MD_DONE : state;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      f3_q  <= '0;
      dz_q  <= 1'b0;
      ov_q  <= 1'b0;
      for (int k = 0; k < MUL_LAT; k++) mp[k] <= '0;
    end else begin
      state <= nxt;
      if (start_ok) begin
        a_q  <= src_a;
        b_q  <= fwd_b;
        f3_q <= i_funct3E;
        dz_q <= b_zero;
        ov_q <= ovf;
        cnt  <= is_div ? CW'(XLEN / DIV_STEP - 1) : CW'(MUL_LAT - 1);
      end else if ((state == MD_MUL || state == MD_DIV) && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      mp[0] <= PW'(ma * mb);
      for (int k = 1; k < MUL_LAT; k++) mp[k] <= mp[k-1];
    end
  end
  // rs1 is signed for MUL/MULH/MULHSU, rs2 only for MUL/MULH.
  assign ma = {{(XLEN+2){(f3_q[1:0] != 2'b11) & a_q[XLEN-1]}}, a_q};
  assign mb = {{(XLEN+2){~f3_q[1] & b_q[XLEN-1]}}, b_q};
  assign lo = mp[MUL_LAT-1][XLEN-1:0];
  assign hi = mp[MUL_LAT-1][PW-1:XLEN];
  assign a_neg = ~i_funct3E[0] & src_a[XLEN-1];
  assign b_neg = ~i_funct3E[0] & fwd_b[XLEN-1];
  assign mag_a = a_neg ? -src_a : src_a;
  assign mag_b = b_neg ? -fwd_b : fwd_b;
  pipe_datapath_execute_md_div #(.XLEN(XLEN), .DIV_STEP(DIV_STEP)) u_div (
    .clk(i_clk),
    .rst(i_rst),
    .start(start_ok & is_div & ~special),
    .en(state == MD_DIV),
    .dividend(mag_a),
    .divisor(mag_b),
    .quo(dq),
    .rem(dr)
  );
  assign sq_neg = ~f3_q[0] & (a_q[XLEN-1] ^ b_q[XLEN-1]);
  assign sr_neg = ~f3_q[0] & a_q[XLEN-1];
  assign quo = dz_q ? '1 : ov_q ? a_q : (sq_neg ? -dq : dq);
  assign rem = dz_q ? a_q : ov_q ? '0 : (sr_neg ? -dr : dr);
  assign md_res = f3_q[2] ? (f3_q[1] ? rem : quo) : (f3_q[1:0] == 2'b00 ? lo : hi);
  assign o_dp_ALU  = (state == MD_DONE) ? md_res : alu_y;
  assign o_md_done = state == MD_DONE;
  assign o_stallE  = ((state == MD_IDLE & i_md_valid) | state == MD_MUL | state == MD_DIV) & ~i_flushE;
endmodule

// File: tb/tb_pipe_datapath_execute_md.sv
// tb_pipe_datapath_execute_md: randomized and directed checks against a behavioural model
module tb_pipe_datapath_execute_md;
  import pipe_datapath_execute_md_pkg::*;
  localparam int MUL_LAT = 2;
  logic i_clk = 1'b0, i_rst = 1'b1;
  logic [31:0] i_dp_RD1E = '0, i_dp_RD2E = '0, i_dp_PCE = '0, i_dp_ImmExtE = '0;
  logic [63:0] i_fwd_data = '0;
  logic [1:0] i_ForwardAE = '0, i_ForwardBE = '0, i_JumpE = '0;
  logic i_ALUSrcE = 1'b0, i_BranchE = 1'b0, i_md_valid = 1'b0, i_flushE = 1'b0;
  logic [3:0] i_ALUCtrlE = '0;
  logic [2:0] i_funct3E = '0;
  logic [31:0] o_dp_ALU, o_dp_WriteDataE, o_dp_PC_Plus_immE;
  logic [1:0] o_PCSrcE;
  logic o_stallE, o_md_done;
  int vectors = 0, miscompares = 0;

  pipe_datapath_execute_md #(.XLEN(32), .N_FWD(3), .MUL_LAT(MUL_LAT), .DIV_STEP(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_dp_RD1E(i_dp_RD1E), .i_dp_RD2E(i_dp_RD2E),
    .i_dp_PCE(i_dp_PCE), .i_dp_ImmExtE(i_dp_ImmExtE), .i_fwd_data(i_fwd_data),
    .i_ForwardAE(i_ForwardAE), .i_ForwardBE(i_ForwardBE), .i_ALUSrcE(i_ALUSrcE),
    .i_ALUCtrlE(i_ALUCtrlE), .i_JumpE(i_JumpE), .i_BranchE(i_BranchE), .i_funct3E(i_funct3E),
    .i_md_valid(i_md_valid), .i_flushE(i_flushE), .o_dp_ALU(o_dp_ALU),
    .o_dp_WriteDataE(o_dp_WriteDataE), .o_dp_PC_Plus_immE(o_dp_PC_Plus_immE),
    .o_PCSrcE(o_PCSrcE), .o_stallE(o_stallE), .o_md_done(o_md_done)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sel_src(logic [1:0] s, logic [31:0] rd, logic [63:0] f);
    if (s == 2'd1) return f[31:0];
    if (s == 2'd2) return f[63:32];
    return rd;
  endfunction

  function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    int sh = int'(b[4:0]);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return $unsigned($signed(a) >>> sh);
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    case (f)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) < $signed(b);
      3'b101: return !($signed(a) < $signed(b));
      3'b110: return a < b;
      3'b111: return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] ref_pcsrc(logic br, logic tk, logic [1:0] j, logic mdv);
    if (mdv) return 2'b00;
    if (br && tk) return 2'b01;
    if (j == 2'b01) return 2'b01;
    if (j == 2'b10) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_md(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    logic [63:0] p;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_stall(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    if (!f[2]) return MUL_LAT + 1;
    if (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic run_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge i_clk);
    i_dp_RD1E = a; i_dp_RD2E = b; i_ForwardAE = 2'd0; i_ForwardBE = 2'd0;
    i_ALUSrcE = 1'b0; i_funct3E = f; i_md_valid = 1'b1; i_JumpE = 2'b01; i_BranchE = 1'b1;
    #1 chk("md_pcsrc_forced", 32'(o_PCSrcE), 32'd0);
    while (o_stallE && n < 100) begin
      n++;
      @(negedge i_clk);
      #1;
    end
    chk($sformatf("md_stall_cycles f3=%0d", f), 32'(n), 32'(ref_stall(f, a, b)));
    chk("md_done_pulse", 32'(o_md_done), 32'd1);
    chk($sformatf("md_result f3=%0d a=%h b=%h", f, a, b), o_dp_ALU, ref_md(f, a, b));
    @(negedge i_clk);
    i_md_valid = 1'b0; i_JumpE = 2'b00; i_BranchE = 1'b0;
    #1 chk("md_done_clear", 32'(o_md_done), 32'd0);
    chk("md_stall_clear", 32'(o_stallE), 32'd0);
  endtask

  task automatic branch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [1:0] exp);
    @(negedge i_clk);
    i_dp_RD1E = a; i_dp_RD2E = b; i_ForwardAE = 2'd0; i_ForwardBE = 2'd0;
    i_funct3E = f; i_BranchE = 1'b1; i_JumpE = 2'b00; i_md_valid = 1'b0;
    #1 chk($sformatf("branch f3=%0d", f), 32'(o_PCSrcE), 32'(exp));
  endtask

  initial begin
    logic any_done;
    repeat (2) @(negedge i_clk);
    #1 chk("reset_stall", 32'(o_stallE), 32'd0);
    chk("reset_done", 32'(o_md_done), 32'd0);
    chk("reset_alu", o_dp_ALU, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    branch(3'b100, 32'hFFFF_FFFF, 32'd1, 2'b01);
    branch(3'b110, 32'hFFFF_FFFF, 32'd1, 2'b00);
    branch(3'b101, 32'd5, 32'd5, 2'b01);
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a, b, sb;
      @(negedge i_clk);
      i_dp_RD1E = pick(); i_dp_RD2E = pick(); i_dp_PCE = $urandom; i_dp_ImmExtE = pick();
      i_fwd_data = {$urandom, $urandom}; i_ForwardAE = 2'($urandom); i_ForwardBE = 2'($urandom);
      i_ALUSrcE = 1'($urandom); i_ALUCtrlE = 4'($urandom); i_JumpE = 2'($urandom);
      i_BranchE = 1'($urandom); i_funct3E = 3'($urandom); i_md_valid = 1'b0;
      a = sel_src(i_ForwardAE, i_dp_RD1E, i_fwd_data);
      b = sel_src(i_ForwardBE, i_dp_RD2E, i_fwd_data);
      sb = i_ALUSrcE ? i_dp_ImmExtE : b;
      #1;
      chk($sformatf("alu op=%0d", i_ALUCtrlE), o_dp_ALU, ref_alu(i_ALUCtrlE, a, sb));
      chk("write_data", o_dp_WriteDataE, b);
      chk("pc_plus_imm", o_dp_PC_Plus_immE, i_dp_PCE + i_dp_ImmExtE);
      chk("pcsrc", 32'(o_PCSrcE), 32'(ref_pcsrc(i_BranchE, ref_taken(i_funct3E, a, b), i_JumpE, 1'b0)));
      chk("idle_stall", 32'(o_stallE), 32'd0);
    end
    run_md(3'd0, 32'd7, 32'hFFFF_FFFD);
    run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_md(3'd2, 32'hFFFF_FFFF, 32'd2);
    run_md(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_md(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_md(3'd5, 32'd1234, 32'd0);
    run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 24; i++) run_md(3'($urandom), pick(), pick());
    @(negedge i_clk);
    i_dp_RD1E = 32'd100; i_dp_RD2E = 32'd7; i_funct3E = 3'd4; i_md_valid = 1'b1;
    repeat (4) @(negedge i_clk);
    i_flushE = 1'b1;
    #1 chk("flush_stall_drop", 32'(o_stallE), 32'd0);
    @(negedge i_clk);
    i_flushE = 1'b0; i_md_valid = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1 any_done |= o_md_done;
      @(negedge i_clk);
    end
    chk("flush_no_done", 32'(any_done), 32'd0);
    run_md(3'd5, 32'd100, 32'd7);
    @(negedge i_clk);
    i_dp_RD1E = 32'd9; i_dp_RD2E = 32'd9; i_funct3E = 3'd0; i_md_valid = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1; i_md_valid = 1'b0;
    #1 chk("rst_mid_mul_stall", 32'(o_stallE), 32'd0);
    chk("rst_mid_mul_done", 32'(o_md_done), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    run_md(3'd0, 32'd9, 32'd9);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
